// File: rtl/data_mem_unit.sv
// M-stage data memory: combinational byte-laned loads, byte-enabled stores, sticky misalignment flag.
// Optional MMIO window (GPIO, 64-bit cycle counter, store counter) under `define DMEM_MMIO_EN.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwr_sgnm,
  input  logic        ld_sgnm,
  input  logic [2:0]  func3m,
  input  logic [31:0] datamem_rd,
  input  logic [31:0] datamem_wr,
  output logic [31:0] read_datam,
  output logic [31:0] gpio_out,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          f3_illegal;
  logic          misaligned;
  logic          fault;
  logic          store_ok;
  logic          ram_we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ram_word;
  logic [31:0]   raw_word;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [31:0]   ext_word;

  assign widx     = datamem_rd[AW+1:2];
  assign lane     = datamem_rd[1:0];
  assign ram_word = mem[widx];

  // Legality of the access width and alignment
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    case (func3m)
      F3_H, F3_HU: misaligned = datamem_rd[0];
      F3_W:        misaligned = |datamem_rd[1:0];
      F3_B, F3_BU: misaligned = 1'b0;
      default:     f3_illegal = 1'b1;
    endcase
  end

  assign fault    = (ld_sgnm | memwr_sgnm) & (f3_illegal | misaligned);
  assign store_ok = memwr_sgnm & ~fault & rst;

  // Byte enables and store data replicated onto every lane it may land in
  always_comb begin
    be    = 4'b0000;
    wdata = datamem_wr;
    case (func3m[1:0])
      2'b00: begin
        be    = 4'(4'b0001 << lane);
        wdata = {4{datamem_wr[7:0]}};
      end
      2'b01: begin
        be    = datamem_rd[1] ? 4'b1100 : 4'b0011;
        wdata = {2{datamem_wr[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

`ifdef DMEM_MMIO_EN
  logic        mmio_sel;
  logic [31:0] gpio_q;
  logic [63:0] cyc_q;
  logic [31:0] stc_q;
  logic [31:0] mmio_word;

  assign mmio_sel = (datamem_rd[31:4] == MMIO_BASE[31:4]);
  assign ram_we   = store_ok & ~mmio_sel;
  assign gpio_out = gpio_q;
  assign raw_word = mmio_sel ? mmio_word : ram_word;

  always_comb begin
    mmio_word = gpio_q;
    case (datamem_rd[3:2])
      2'b00:   mmio_word = gpio_q;
      2'b01:   mmio_word = cyc_q[31:0];
      2'b10:   mmio_word = cyc_q[63:32];
      default: mmio_word = stc_q;
    endcase
  end

  // Read-only offsets silently drop writes but the store still counts
  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_q <= 32'h0;
      cyc_q  <= 64'h0;
      stc_q  <= 32'h0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (store_ok) begin
        stc_q <= stc_q + 32'd1;
        if (mmio_sel && datamem_rd[3:2] == 2'b00) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) gpio_q[8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign ram_we     = store_ok;
  assign gpio_out   = 32'h0;
  assign raw_word   = ram_word;
  assign unused_cfg = ^{datamem_rd[31:AW+2], MMIO_BASE};
`endif

  // Lane extraction and extension; faulting accesses read as zero
  always_comb begin
    sel_b    = 8'(raw_word >> {lane, 3'b000});
    sel_h    = 16'(raw_word >> {datamem_rd[1], 4'b0000});
    ext_word = 32'h0;
    case (func3m)
      F3_B:    ext_word = {{24{sel_b[7]}}, sel_b};
      F3_H:    ext_word = {{16{sel_h[15]}}, sel_h};
      F3_W:    ext_word = raw_word;
      F3_BU:   ext_word = {24'h0, sel_b};
      F3_HU:   ext_word = {16'h0, sel_h};
      default: ext_word = 32'h0;
    endcase
    read_datam = fault ? 32'h0 : ext_word;
  end

  // RAM is not reset; a store pending during reset is dropped via store_ok
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Sticky error flag; only the first faulting address is kept
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err <= 1'b0;
      err_addr     <= 32'h0;
    end else if (fault) begin
      misalign_err <= 1'b1;
      if (!misalign_err) err_addr <= datamem_rd;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit; MMIO scenarios run when DMEM_MMIO_EN is defined.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwr;
  logic        ld;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic [31:0] gpio;
  logic        merr;
  logic [31:0] eaddr;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  data_mem_unit dut (
    .clk(clk), .rst(rst), .memwr_sgnm(memwr), .ld_sgnm(ld), .func3m(f3),
    .datamem_rd(addr), .datamem_wr(wd), .read_datam(rdata),
    .gpio_out(gpio), .misalign_err(merr), .err_addr(eaddr)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    memwr = 1'b1; ld = 1'b0; addr = a; wd = d; f3 = f;
    @(negedge clk);
    memwr = 1'b0;
  endtask

  // Samples the combinational result, then keeps the load active across one edge
  task automatic do_load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] r);
    @(negedge clk);
    memwr = 1'b0; ld = 1'b1; addr = a; f3 = f;
    #1 r = rdata;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; memwr = 1'b0; ld = 1'b0; f3 = W; addr = 32'h0; wd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gpio !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h exp %h", gpio, 32'h0); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL reset_merr got %b exp 0", merr); end
    checks++; if (eaddr !== 32'h0) begin errors++; $display("FAIL reset_eaddr got %h exp 0", eaddr); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_no_fault();
    @(negedge clk);
    ld = 1'b0; memwr = 1'b0; addr = 32'h3; f3 = W;
    @(posedge clk);
    #1;
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL idle_no_fault got %b exp 0", merr); end
  endtask

  task automatic test_lanes();
    logic [31:0] r;
    do_store(32'h10, 32'hDEAD_BEEF, W);
    do_load(32'h10, W, r);
    checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_10 got %h exp %h", r, 32'hDEAD_BEEF); end
    do_load(32'h13, B, r);
    checks++; if (r !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_13 got %h exp %h", r, 32'hFFFF_FFDE); end
    do_load(32'h12, BU, r);
    checks++; if (r !== 32'h0000_00AD) begin errors++; $display("FAIL lbu_12 got %h exp %h", r, 32'h0000_00AD); end
    do_load(32'h10, H, r);
    checks++; if (r !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_10 got %h exp %h", r, 32'hFFFF_BEEF); end
    do_load(32'h12, HU, r);
    checks++; if (r !== 32'h0000_DEAD) begin errors++; $display("FAIL lhu_12 got %h exp %h", r, 32'h0000_DEAD); end
    do_load(32'h11, BU, r);
    checks++; if (r !== 32'h0000_00BE) begin errors++; $display("FAIL lbu_11 got %h exp %h", r, 32'h0000_00BE); end
    do_load(32'h10, B, r);
    checks++; if (r !== 32'hFFFF_FFEF) begin errors++; $display("FAIL lb_10 got %h exp %h", r, 32'hFFFF_FFEF); end
  endtask

  task automatic test_partial_stores();
    logic [31:0] r;
    do_store(32'h20, 32'h0, W);
    do_store(32'h21, 32'hFFFF_FF12, B);
    do_load(32'h20, W, r);
    checks++; if (r !== 32'h0000_1200) begin errors++; $display("FAIL sb_21 got %h exp %h", r, 32'h0000_1200); end
    do_store(32'h22, 32'h5555_ABCD, H);
    do_load(32'h20, W, r);
    checks++; if (r !== 32'hABCD_1200) begin errors++; $display("FAIL sh_22 got %h exp %h", r, 32'hABCD_1200); end
    do_store(32'h20, 32'h0000_0034, B);
    do_load(32'h20, W, r);
    checks++; if (r !== 32'hABCD_1234) begin errors++; $display("FAIL sb_20 got %h exp %h", r, 32'hABCD_1234); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] r;
    @(negedge clk);
    memwr = 1'b1; ld = 1'b1; addr = 32'h20; wd = 32'h1111_1111; f3 = W;
    #1;
    checks++; if (rdata !== 32'hABCD_1234) begin errors++; $display("FAIL rdw_old got %h exp %h", rdata, 32'hABCD_1234); end
    @(negedge clk);
    memwr = 1'b0; ld = 1'b0;
    do_load(32'h20, W, r);
    checks++; if (r !== 32'h1111_1111) begin errors++; $display("FAIL rdw_new got %h exp %h", r, 32'h1111_1111); end
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    do_store(32'h1000, 32'h55, W);
    do_load(32'h0, W, r);
    checks++; if (r !== 32'h55) begin errors++; $display("FAIL wrap got %h exp %h", r, 32'h55); end
  endtask

  task automatic test_fault();
    logic [31:0] r;
    logic [31:0] c0;
    logic [31:0] c1;
    c0 = 32'h0;
    c1 = 32'h0;
    do_store(32'h14, 32'h1234_5678, W);
`ifdef DMEM_MMIO_EN
    do_load(32'hFFFF_000C, W, c0);
`endif
    do_store(32'h16, 32'hFFFF_FFFF, W);
    #1;
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL fault_flag got %b exp 1", merr); end
    checks++; if (eaddr !== 32'h16) begin errors++; $display("FAIL fault_addr got %h exp %h", eaddr, 32'h16); end
    do_load(32'h31, H, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL lh_misaligned got %h exp 0", r); end
    checks++; if (eaddr !== 32'h16) begin errors++; $display("FAIL fault_addr_kept got %h exp %h", eaddr, 32'h16); end
    do_load(32'h14, W, r);
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL store_suppressed got %h exp %h", r, 32'h1234_5678); end
    do_load(32'h14, 3'b011, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL illegal_f3 got %h exp 0", r); end
    do_store(32'h14, 32'hAAAA_AAAA, 3'b111);
    do_load(32'h14, W, r);
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL illegal_store got %h exp %h", r, 32'h1234_5678); end
`ifdef DMEM_MMIO_EN
    do_load(32'hFFFF_000C, W, c1);
    checks++; if (c1 !== c0) begin errors++; $display("FAIL fault_stcnt got %h exp %h", c1, c0); end
`endif
  endtask

  task automatic test_mmio();
    logic [31:0] r;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] c0;
`ifdef DMEM_MMIO_EN
    do_load(32'hFFFF_000C, W, c0);
    do_store(32'hFFFF_0000, 32'hA5, W);
    #1;
    checks++; if (gpio !== 32'hA5) begin errors++; $display("FAIL gpio_sw got %h exp %h", gpio, 32'hA5); end
    do_store(32'hFFFF_0002, 32'h1234, H);
    #1;
    checks++; if (gpio !== 32'h1234_00A5) begin errors++; $display("FAIL gpio_sh got %h exp %h", gpio, 32'h1234_00A5); end
    do_load(32'hFFFF_0002, B, r);
    checks++; if (r !== 32'h34) begin errors++; $display("FAIL gpio_lb got %h exp %h", r, 32'h34); end
    do_store(32'hFFFF_0004, 32'h0, W);
    do_load(32'hFFFF_000C, W, r);
    checks++; if (r !== c0 + 32'd3) begin errors++; $display("FAIL stcnt got %h exp %h", r, c0 + 32'd3); end
    @(negedge clk);
    ld = 1'b1; addr = 32'hFFFF_0004; f3 = W;
    #1 r1 = rdata;
    repeat (7) @(negedge clk);
    #1 r2 = rdata;
    ld = 1'b0;
    checks++; if (r2 - r1 !== 32'd7) begin errors++; $display("FAIL cyc_delta got %0d exp 7", r2 - r1); end
    checks++; if (r1 < 32'd20) begin errors++; $display("FAIL cyc_ro got %0d exp >=20", r1); end
`else
    r = 32'h0; r1 = 32'h0; r2 = 32'h0; c0 = 32'h0;
    do_store(32'hFFFF_0000, 32'hA5, W);
    #1;
    checks++; if (gpio !== 32'h0) begin errors++; $display("FAIL gpio_tied got %h exp 0", gpio); end
    do_load(32'h0, W, r);
    checks++; if (r !== 32'hA5) begin errors++; $display("FAIL nommio_alias got %h exp %h", r, 32'hA5); end
    do_store(32'h0, 32'h55, W);
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    @(negedge clk);
    rst = 1'b0; memwr = 1'b1; ld = 1'b0; addr = 32'h0; wd = 32'h77; f3 = W;
    @(posedge clk);
    #1;
    checks++; if (gpio !== 32'h0) begin errors++; $display("FAIL rst_gpio got %h exp 0", gpio); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL rst_merr got %b exp 0", merr); end
    checks++; if (eaddr !== 32'h0) begin errors++; $display("FAIL rst_eaddr got %h exp 0", eaddr); end
    @(negedge clk);
    rst = 1'b1; memwr = 1'b0;
`ifdef DMEM_MMIO_EN
    ld = 1'b1; addr = 32'hFFFF_0004; f3 = W;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_cyc0 got %h exp 0", rdata); end
    @(posedge clk);
    #1;
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL rst_cyc1 got %h exp 1", rdata); end
    ld = 1'b0;
    do_load(32'hFFFF_000C, W, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_stcnt got %h exp 0", r); end
`endif
    do_load(32'h0, W, r);
    checks++; if (r !== 32'h55) begin errors++; $display("FAIL rst_drop_store got %h exp %h", r, 32'h55); end
    do_load(32'h10, W, r);
    checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_ram_kept got %h exp %h", r, 32'hDEAD_BEEF); end
  endtask

  initial begin
    test_reset();
    test_idle_no_fault();
    test_lanes();
    test_partial_stores();
    test_read_during_write();
    test_wrap();
    test_mmio();
    test_fault();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Memory-stage data memory for the 5-stage RISC-V pipeline. It takes the M-stage address, store data, write strobe and funct3 from the datapath. It returns load data, already byte-laned and sign/zero-extended, in the same cycle so the M/W pipeline register can capture it. It also holds a small memory-mapped I/O window (GPIO register and counters) and a sticky misalignment error flag.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window (only with DMEM_MMIO_EN).
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- memwr_sgnm  input  1  store strobe for the M-stage instruction.
- ld_sgnm  input  1  M-stage instruction is a load (result_sgnm == 2'b01).
- func3m  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- datamem_rd  input  32  byte address (alu_resultm).
- datamem_wr  input  32  store data (rd_final2m); low bytes used for SB/SH.
- read_datam  output  32  extended load data, combinational.
- gpio_out  output  32  GPIO register.
- misalign_err  output  1  sticky error flag.
- err_addr  output  32  address of the first faulting access.

## Operation
- Word index is datamem_rd[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so RAM aliases/wraps.
- Loads are combinational array reads. Lane select uses addr[1:0] for bytes and addr[1] for halfwords.
  - B/H loads sign-extend; BU/HU zero-extend; W passes through.
- Stores use per-byte enables. SB writes lane addr[1:0] with datamem_wr[7:0]; SH writes lanes {addr[1],0},{addr[1],1} with datamem_wr[15:0]; SW writes all four lanes.
- Faulting access: an active load or store whose alignment or func3 is illegal.
  - Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0.
  - Illegal func3: 011, 110, 111.
- Effect of a fault:
  - The store is suppressed: no RAM/MMIO change and no store count.
  - The load returns 32'h0.
  - On the next edge misalign_err is set. If it was clear, err_addr captures datamem_rd. Later faults do not overwrite err_addr.
- When ld_sgnm=0 and memwr_sgnm=0, read_datam still shows the extended read (don't-care to the pipeline), and no fault is raised.
- memwr_sgnm and ld_sgnm both 1 is illegal upstream. Store semantics take priority and read_datam is the pre-write value.
- MMIO window (with macro): addr[31:4] == MMIO_BASE[31:4] selects MMIO instead of RAM.
  - +0x0 GPIO: read/write, byte-lane writes as for RAM.
  - +0x4: cycle counter [31:0], read-only.
  - +0x8: cycle counter [63:32], read-only.
  - +0xC: committed-store counter, read-only, 32-bit, wraps.
  - Stores to read-only registers are ignored with no fault, but still count as committed.
  - Narrow loads from MMIO extract lanes exactly as RAM does.
- Cycle counter: 64-bit, +1 every clock when not in reset, wraps at 2^64.
- Store counter: +1 per committed (non-faulting) store, including MMIO stores.

## Timing
- Load latency 0: read_datam is valid in the same cycle as the address.
- Stores commit on the rising edge at the end of the M cycle.
- Read-during-write to the same word returns old data. A load in the following cycle sees the new data.
- Reset (rst=0 at an edge) clears:
  - gpio_out=0, misalign_err=0, err_addr=0;
  - both counters to 0;
  - any pending store in that cycle (dropped).
- RAM contents are not reset.
- Reset mid-operation: the first edge with rst=1 leaves cycle counter = 1.
- read_datam during reset follows combinational RAM contents.

## Configuration
- DMEM_MMIO_EN defined: MMIO window, gpio_out register and both counters are present as described.
- DMEM_MMIO_EN undefined:
  - There is no MMIO decode; every address maps to RAM by wrap.
  - gpio_out is tied to 32'h0.
  - Counter logic is absent.
  - Misalignment checking is unchanged.

## Test plan
- SW 0xDEADBEEF @0x10, then LW/LB/LBU/LH/LHU at 0x10–0x13 -> LW=0xDEADBEEF; LB@0x13=0xFFFFFFDE; LBU@0x12=0x000000AD; LH@0x10=0xFFFFBEEF; LHU@0x12=0x0000DEAD.
- SB 0x12 @0x21 over word 0 -> LW@0x20=0x00001200. Then SH 0xABCD @0x22 -> LW@0x20=0xABCD1200.
- SW @0x16 (misaligned), then LH @0x31 -> word 0x14 unchanged; LH returns 0; misalign_err=1 with err_addr=0x16, not 0x31; store counter unchanged.
- With DMEM_MMIO_EN: SW 0xA5 to 0xFFFF0000 -> gpio_out=0x000000A5 the next cycle. SW to 0xFFFF0004 -> ignored. Two LW reads of +0x4 N cycles apart differ by N.
- Address wrap: DEPTH_WORDS=1024, SW 0x55 @0x1000 -> LW@0x0 = 0x55.
- Assert rst=0 for one cycle after activity -> gpio_out, counters, misalign_err and err_addr are all 0, while previously written RAM data remains readable.
